// File: rtl/pixel_packer_pkg.sv
// Shared types and constants for the pixel_packer block.
package pixel_packer_pkg;

   // Packing FSM states.
   typedef enum logic {
      WAIT_SOF = 1'b0,
      PACK     = 1'b1
   } state_t;

   localparam int unsigned LANE_W              = 16;
   localparam int unsigned PIXELS_PER_WORD     = 8;
   localparam int unsigned DEFAULT_FRAME_WORDS = 115200;
   localparam int unsigned WORD_W              = LANE_W * PIXELS_PER_WORD;
   localparam int unsigned ENTRY_W             = WORD_W + 1;
   localparam int unsigned CNT_W               = 17;
   localparam int unsigned LANE_IDX_W          = 3;

endpackage

// File: rtl/word_skid_fifo.sv
// Two-entry FIFO between the packer and the AXI-Stream consumer.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module word_skid_fifo
   import pixel_packer_pkg::*;
#(
   parameter int unsigned W = ENTRY_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         do_push;
   logic         do_pop;

   assign pop_valid  = (count != 2'd0);
   assign push_ready = (count != 2'd2) || pop_ready;
   assign pop_data   = mem[rd_ptr];
   assign do_push    = push_valid && push_ready;
   assign do_pop     = pop_valid && pop_ready;

   // Storage, pointers and occupancy; a full-buffer push overwrites the slot being popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_packer.sv
// Packs RGB565 pixels eight to a 128-bit AXI-Stream word, framed by SOF.
// Optional statistics outputs are built when PIXEL_PACKER_STATS_EN is defined.
module pixel_packer
   import pixel_packer_pkg::*;
#(
   parameter int unsigned FRAME_WORDS     = pixel_packer_pkg::DEFAULT_FRAME_WORDS,
   parameter int unsigned PIXELS_PER_WORD = pixel_packer_pkg::PIXELS_PER_WORD
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                pixel_valid_in,
   input  logic [LANE_W-1:0]   pixel_data_in,
   input  logic                pixel_sof_in,
   output logic [WORD_W-1:0]   m_axis_data,
   output logic                m_axis_tlast,
   output logic                m_axis_valid,
   input  logic                m_axis_ready,
   output logic                frame_drop_out,
   output logic                sof_err_out
`ifdef PIXEL_PACKER_STATS_EN
   ,
   output logic [15:0]         frames_out,
   output logic [15:0]         drops_out
`endif
);

   localparam int unsigned ACC_W = LANE_W * (PIXELS_PER_WORD - 1);
   localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(PIXELS_PER_WORD - 1);

   state_t                 state, state_n;
   logic [LANE_IDX_W-1:0]  lane, lane_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [ACC_W-1:0]       acc, acc_n;
   logic                   push;
   logic                   push_ready;
   logic                   word_last;
   logic                   drop_n;
   logic                   sof_err_n;
   logic [ENTRY_W-1:0]     push_entry;
   logic [ENTRY_W-1:0]     pop_entry;

   // Lane 7 never lands in the accumulator: it goes straight into the pushed word.
   assign word_last  = (cnt == CNT_W'(FRAME_WORDS - 1));
   assign push_entry = {word_last, pixel_data_in, acc};

   // State, lane/word counters, partial-word accumulator and status pulses.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= WAIT_SOF;
         lane           <= '0;
         cnt            <= '0;
         acc            <= '0;
         frame_drop_out <= 1'b0;
         sof_err_out    <= 1'b0;
      end else begin
         state          <= state_n;
         lane           <= lane_n;
         cnt            <= cnt_n;
         acc            <= acc_n;
         frame_drop_out <= drop_n;
         sof_err_out    <= sof_err_n;
      end
   end

   // Next-state, lane placement, word push and drop/early-SOF detection.
   always_comb begin
      state_n   = state;
      lane_n    = lane;
      cnt_n     = cnt;
      acc_n     = acc;
      push      = 1'b0;
      drop_n    = 1'b0;
      sof_err_n = 1'b0;
      case (state)
         WAIT_SOF: begin
            if (pixel_valid_in && pixel_sof_in) begin
               acc_n                = '0;
               acc_n[LANE_W-1:0]    = pixel_data_in;
               lane_n               = LANE_IDX_W'(1);
               cnt_n                = '0;
               state_n              = PACK;
            end
         end
         PACK: begin
            if (pixel_valid_in) begin
               if (pixel_sof_in && (lane != '0 || cnt != '0)) begin
                  sof_err_n         = 1'b1;
                  acc_n             = '0;
                  acc_n[LANE_W-1:0] = pixel_data_in;
                  lane_n            = LANE_IDX_W'(1);
                  cnt_n             = '0;
               end else if (lane == LAST_LANE) begin
                  push   = 1'b1;
                  lane_n = '0;
                  if (!push_ready) begin
                     drop_n  = 1'b1;
                     cnt_n   = '0;
                     state_n = WAIT_SOF;
                  end else if (word_last) begin
                     cnt_n   = '0;
                     state_n = WAIT_SOF;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  for (int unsigned i = 0; i < PIXELS_PER_WORD - 1; i++) begin
                     if (lane == LANE_IDX_W'(i)) acc_n[i*LANE_W +: LANE_W] = pixel_data_in;
                  end
                  lane_n = lane + 1'b1;
               end
            end
         end
         default: state_n = WAIT_SOF;
      endcase
   end

   word_skid_fifo #(
      .W (ENTRY_W)
   ) u_fifo (
      .clk        (clk_in),
      .rst_n      (rst_in),
      .push_valid (push),
      .push_ready (push_ready),
      .push_data  (push_entry),
      .pop_valid  (m_axis_valid),
      .pop_ready  (m_axis_ready),
      .pop_data   (pop_entry)
   );

   assign m_axis_data  = pop_entry[WORD_W-1:0];
   assign m_axis_tlast = pop_entry[WORD_W];

`ifdef PIXEL_PACKER_STATS_EN
   // Saturating counts of delivered frames and of abandoned frames.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         frames_out <= '0;
         drops_out  <= '0;
      end else begin
         if (m_axis_valid && m_axis_ready && m_axis_tlast && frames_out != '1)
            frames_out <= frames_out + 1'b1;
         if ((frame_drop_out || sof_err_out) && drops_out != '1)
            drops_out <= drops_out + 1'b1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer with a 4-word frame.
module tb_pixel_packer;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          pixel_valid_in = 1'b0;
   logic [15:0]   pixel_data_in = '0;
   logic          pixel_sof_in = 1'b0;
   logic          m_axis_ready = 1'b0;
   logic [127:0]  m_axis_data;
   logic          m_axis_tlast;
   logic          m_axis_valid;
   logic          frame_drop_out;
   logic          sof_err_out;
`ifdef PIXEL_PACKER_STATS_EN
   logic [15:0]   frames_out;
   logic [15:0]   drops_out;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pixel_packer #(
      .FRAME_WORDS     (4),
      .PIXELS_PER_WORD (8)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .pixel_valid_in (pixel_valid_in),
      .pixel_data_in  (pixel_data_in),
      .pixel_sof_in   (pixel_sof_in),
      .m_axis_data    (m_axis_data),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_valid   (m_axis_valid),
      .m_axis_ready   (m_axis_ready),
      .frame_drop_out (frame_drop_out),
      .sof_err_out    (sof_err_out)
`ifdef PIXEL_PACKER_STATS_EN
      ,
      .frames_out     (frames_out),
      .drops_out      (drops_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [127:0] mkword(input logic [15:0] base);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) w[i*16 +: 16] = base + 16'(i);
      return w;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send_pix(input logic [15:0] d, input logic s);
      pixel_valid_in = 1'b1;
      pixel_data_in  = d;
      pixel_sof_in   = s;
      tick();
      pixel_valid_in = 1'b0;
      pixel_sof_in   = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] base, input logic s, input logic last,
                            input logic check, input string tag);
      for (int i = 0; i < 8; i++) send_pix(base + 16'(i), s && (i == 0));
      if (check) begin
         chk({tag, "_valid"}, 128'(m_axis_valid), 128'(1'b1));
         chk({tag, "_data"},  m_axis_data, mkword(base));
         chk({tag, "_tlast"}, 128'(m_axis_tlast), 128'(last));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      tick();
      tick();
      chk("rst_valid", 128'(m_axis_valid), 128'(1'b0));
      chk("rst_tlast", 128'(m_axis_tlast), 128'(1'b0));
      chk("rst_data",  m_axis_data, '0);
      chk("rst_drop",  128'(frame_drop_out), 128'(1'b0));
      chk("rst_soferr", 128'(sof_err_out), 128'(1'b0));
      rst_in = 1'b1;
      tick();

      // Pixels without SOF are discarded
      m_axis_ready = 1'b1;
      send_word(16'h0040, 1'b0, 1'b0, 1'b0, "nosof");
      chk("nosof_valid", 128'(m_axis_valid), 128'(1'b0));

      // Pack order and latency, then the rest of a 4-word frame
      send_pix(16'h0000, 1'b1);
      for (int i = 1; i < 7; i++) send_pix(16'(i), 1'b0);
      chk("lat_valid_early", 128'(m_axis_valid), 128'(1'b0));
      send_pix(16'h0007, 1'b0);
      chk("w0_valid", 128'(m_axis_valid), 128'(1'b1));
      chk("w0_data",  m_axis_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
      chk("w0_tlast", 128'(m_axis_tlast), 128'(1'b0));
      send_word(16'h0008, 1'b0, 1'b0, 1'b1, "w1");
      send_word(16'h0010, 1'b0, 1'b0, 1'b1, "w2");
      send_word(16'h0018, 1'b0, 1'b1, 1'b1, "w3");
      tick();
      chk("frame_end_valid", 128'(m_axis_valid), 128'(1'b0));
      send_word(16'h0020, 1'b0, 1'b0, 1'b0, "idle");
      chk("back_to_wait_sof", 128'(m_axis_valid), 128'(1'b0));

      // Full buffer with push and pop in the same cycle
      m_axis_ready = 1'b0;
      send_word(16'h0200, 1'b1, 1'b0, 1'b0, "f2w0");
      send_word(16'h0210, 1'b0, 1'b0, 1'b0, "f2w1");
      for (int i = 0; i < 7; i++) send_pix(16'h0220 + 16'(i), 1'b0);
      m_axis_ready = 1'b1;
      send_pix(16'h0227, 1'b0);
      chk("pushpop_nodrop", 128'(frame_drop_out), 128'(1'b0));
      chk("pushpop_head",   m_axis_data, mkword(16'h0210));
      tick();
      chk("pushpop_next",   m_axis_data, mkword(16'h0220));
      chk("pushpop_valid",  128'(m_axis_valid), 128'(1'b1));
      tick();
      chk("pushpop_empty",  128'(m_axis_valid), 128'(1'b0));
      send_word(16'h0230, 1'b0, 1'b1, 1'b1, "f2w3");
      tick();

      // Backpressure overflow drops the frame; buffered words still drain
      m_axis_ready = 1'b0;
      send_word(16'h0100, 1'b1, 1'b0, 1'b0, "bp0");
      send_word(16'h0110, 1'b0, 1'b0, 1'b0, "bp1");
      chk("bp_head", m_axis_data, mkword(16'h0100));
      send_word(16'h0120, 1'b0, 1'b0, 1'b0, "bp2");
      chk("bp_drop_pulse", 128'(frame_drop_out), 128'(1'b1));
      chk("bp_head_stable", m_axis_data, mkword(16'h0100));
      tick();
      chk("bp_drop_clear", 128'(frame_drop_out), 128'(1'b0));
      send_word(16'h0130, 1'b0, 1'b0, 1'b0, "bp3");
      chk("bp_hold_valid", 128'(m_axis_valid), 128'(1'b1));
      chk("bp_hold_data",  m_axis_data, mkword(16'h0100));
      chk("bp_hold_tlast", 128'(m_axis_tlast), 128'(1'b0));
      m_axis_ready = 1'b1;
      tick();
      chk("bp_drain2_valid", 128'(m_axis_valid), 128'(1'b1));
      chk("bp_drain2_data",  m_axis_data, mkword(16'h0110));
      tick();
      chk("bp_drained", 128'(m_axis_valid), 128'(1'b0));
      tick();
      chk("bp_no_third", 128'(m_axis_valid), 128'(1'b0));

      // Early SOF at lane 3 of word 1
      send_word(16'h0300, 1'b1, 1'b0, 1'b1, "esA0");
      send_pix(16'h0310, 1'b0);
      send_pix(16'h0311, 1'b0);
      send_pix(16'h0312, 1'b0);
      chk("es_no_err_yet", 128'(sof_err_out), 128'(1'b0));
      send_pix(16'h0400, 1'b1);
      chk("es_err_pulse", 128'(sof_err_out), 128'(1'b1));
      chk("es_no_partial", 128'(m_axis_valid), 128'(1'b0));
      send_pix(16'h0401, 1'b0);
      chk("es_err_clear", 128'(sof_err_out), 128'(1'b0));
      for (int i = 2; i < 8; i++) send_pix(16'h0400 + 16'(i), 1'b0);
      chk("esB0_valid", 128'(m_axis_valid), 128'(1'b1));
      chk("esB0_data",  m_axis_data, mkword(16'h0400));
      chk("esB0_tlast", 128'(m_axis_tlast), 128'(1'b0));
      send_word(16'h0408, 1'b0, 1'b0, 1'b1, "esB1");
      send_word(16'h0410, 1'b0, 1'b0, 1'b1, "esB2");
      send_word(16'h0418, 1'b0, 1'b1, 1'b1, "esB3");
      tick();
      chk("esB_end", 128'(m_axis_valid), 128'(1'b0));

      // Reset mid-frame with a full buffer clears output asynchronously
      m_axis_ready = 1'b0;
      send_word(16'h0500, 1'b1, 1'b0, 1'b0, "rm0");
      send_word(16'h0510, 1'b0, 1'b0, 1'b0, "rm1");
      chk("rm_full_valid", 128'(m_axis_valid), 128'(1'b1));
      send_pix(16'h0520, 1'b0);
      send_pix(16'h0521, 1'b0);
      #3;
      rst_in = 1'b0;
      #1;
      chk("rm_async_valid", 128'(m_axis_valid), 128'(1'b0));
      chk("rm_async_data",  m_axis_data, '0);
      #2;
      rst_in = 1'b1;
      tick();
      m_axis_ready = 1'b1;
      send_word(16'h0600, 1'b0, 1'b0, 1'b0, "rm_nosof");
      chk("rm_nosof_valid", 128'(m_axis_valid), 128'(1'b0));
      send_word(16'h0700, 1'b1, 1'b0, 1'b1, "rm_new");
      tick();

`ifdef PIXEL_PACKER_STATS_EN
      // Three delivered frames and one dropped frame
      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
      tick();
      m_axis_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         send_word(16'h0800 + 16'(f * 64),      1'b1, 1'b0, 1'b0, "st");
         send_word(16'h0808 + 16'(f * 64),      1'b0, 1'b0, 1'b0, "st");
         send_word(16'h0810 + 16'(f * 64),      1'b0, 1'b0, 1'b0, "st");
         send_word(16'h0818 + 16'(f * 64),      1'b0, 1'b1, 1'b0, "st");
      end
      tick();
      m_axis_ready = 1'b0;
      send_word(16'h0A00, 1'b1, 1'b0, 1'b0, "sd");
      send_word(16'h0A08, 1'b0, 1'b0, 1'b0, "sd");
      send_word(16'h0A10, 1'b0, 1'b0, 1'b0, "sd");
      m_axis_ready = 1'b1;
      tick();
      tick();
      tick();
      chk("stats_frames", 128'(frames_out), 128'(16'd3));
      chk("stats_drops",  128'(drops_out),  128'(16'd1));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 115200: 128-bit words per frame (1280x720 RGB565 / 8).
REQ-002 SHALL have parameter PIXELS_PER_WORD, default 8: 16-bit pixels per output word; fixed at 8.
REQ-003 SHALL have ports:
  - clk_in, input, 1: single clock (DDR3 ui clk domain).
  - rst_in, input, 1: asynchronous, active-low reset.
  - pixel_valid_in, input, 1: pixel strobe; no backpressure.
  - pixel_data_in, input, 16: RGB565 pixel.
  - pixel_sof_in, input, 1: qualifies pixel as first of frame; ignored unless pixel_valid_in.
  - m_axis_data, output, 128: packed word.
  - m_axis_tlast, output, 1: last word of frame.
  - m_axis_valid, output, 1: word available.
  - m_axis_ready, input, 1: consumer accepts.
  - frame_drop_out, output, 1: one-cycle pulse, frame abandoned.
  - sof_err_out, output, 1: one-cycle pulse, early SOF.
REQ-004 Only one clock; reset asynchronous active-low; all flops SHALL clear on rst_in low without a clock edge.

Function
REQ-005 SHALL implement states WAIT_SOF and PACK.
REQ-006 In WAIT_SOF, pixels without SOF SHALL be discarded.
REQ-007 pixel_valid_in&&pixel_sof_in SHALL load that pixel as lane 0 with word count 0, then go to PACK.
REQ-008 In PACK, each valid pixel SHALL be written to bits [16*lane+15:16*lane]; lane 0 is the LSBs; lane increments mod 8.
REQ-009 On lane 7, the completed word SHALL be pushed to the output buffer with tlast = (word count == FRAME_WORDS-1); word count then increments.
REQ-010 After the tlast word is pushed, the block SHALL return to WAIT_SOF.
REQ-011 Latency: when the buffer is empty, a word completed at cycle N SHALL have m_axis_valid high at N+1.
REQ-012 The output buffer SHALL hold 2 entries and be FIFO-ordered. Handshake: a transfer occurs on valid&&ready; data and tlast SHALL be held stable while valid&&!ready.
REQ-013 Simultaneous push and pop SHALL succeed when the buffer is full (pop frees a slot the same cycle).
REQ-014 Push into a full buffer with no pop SHALL:
  - discard the word;
  - pulse frame_drop_out;
  - abandon the frame and go to WAIT_SOF.
  Words already buffered SHALL still drain.
REQ-015 SOF in PACK with lane!=0 or word count!=0:
  - the partial word SHALL be discarded;
  - sof_err_out SHALL pulse;
  - the pixel restarts the frame as in REQ-007;
  - no tlast SHALL be emitted for the truncated frame.
REQ-016 Word count SHALL be 17 bits, compared against FRAME_WORDS-1, and never exceed it.
REQ-017 Pixels arriving on consecutive cycles SHALL all be accepted; 8 back-to-back pixels yield exactly one word.

Reset
REQ-018 Reset values:
  - state WAIT_SOF; lane 0; word count 0; buffer empty.
  - m_axis_valid 0; m_axis_tlast 0; m_axis_data 0.
  - frame_drop_out 0; sof_err_out 0.
REQ-019 Reset mid-frame SHALL discard all buffered and partial data; the first post-reset word SHALL come only after a new SOF.

Configuration
REQ-020 Macro PIXEL_PACKER_STATS_EN defined SHALL add two outputs:
  - frames_out (16 bits): counts tlast transfers.
  - drops_out (16 bits): counts frame_drop_out plus sof_err_out pulses.
  Both SHALL saturate at 0xFFFF and reset to 0.
REQ-021 Without PIXEL_PACKER_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-022 Package pixel_packer_pkg SHALL hold the state enum, PIXELS_PER_WORD, the default FRAME_WORDS, and LANE_W=16.
REQ-023 The 2-entry buffer SHALL be sub-module word_skid_fifo, with 129-bit entries (data+tlast) and a valid/ready interface on both sides.

Verification
REQ-024 Pack order: SOF then pixels 0x0000..0x0007, ready=1 -> one word 0x0007000600050004000300020001_0000, tlast=0, valid 1 cycle after pixel 7.
REQ-025 Full frame: FRAME_WORDS=4 sim override, 32 pixels after SOF, ready=1 -> 4 words, tlast only on the 4th; then state WAIT_SOF.
REQ-026 Backpressure: ready=0 for 16 pixels -> 2 words held stable; next word pushes -> frame_drop_out pulses once; after ready=1, exactly 2 words drain.
REQ-027 Early SOF at lane 3 of word 1 -> sof_err_out pulses; next word output is the new frame's lane-0 pixel onward; no tlast for the aborted frame.
REQ-028 Pixels without SOF after reset -> no output; rst_in low mid-frame with a full buffer -> m_axis_valid 0 immediately, asynchronously.
REQ-029 With PIXEL_PACKER_STATS_EN defined: 3 complete frames plus 1 dropped frame -> frames_out=3, drops_out=1.
